fifoi_read_sched: RTL and testbench
===================================

Name: fifoi_read_sched

Overview:
- Read-side scheduler for the two per-chip ADC sample FIFOs (fifoi channel 1 = bits [15:8], channel 0 = bits [7:0]).
- On a read start, it drains exactly the per-device byte count from each channel, channel 1 first, then channel 0.
- It serialises the bytes onto a single valid/ready byte stream for the upstream packetiser, then raises done.
- Runs in the fifoi read-clock domain; clk is the FIFO rd_clk.

Parameters:
- TO_CYC, 1024, cycles the scheduler waits on a non-empty FIFO before flagging err.
- LEN_W, 12, width of the per-channel byte counters.

Ports:
- clk  in  1  FIFO read clock
- rst  in  1  asynchronous, active-high reset
- fs  in  1  start/hold request from the frame controller
- fd  out  1  done; high while in DONE
- err  out  1  timeout flag
- dev_type  in  2  detected device kind, sampled in LOAD
- fifoi_rxen  out  2  per-channel FIFO read enable, one-hot or zero
- fifoi_rxd  in  16  FIFO data; [15:8] channel 1, [7:0] channel 0
- fifoi_empty  in  2  per-channel FIFO empty
- dout  out  8  output byte
- dout_vld  out  1  output byte valid
- dout_rdy  in  1  downstream accept
- so  out  8  current state code, for debug

Behaviour:
- Reset values: fd=0, err=0, dout=8'h00, dout_vld=0, fifoi_rxen=2'b00, so=IDLE.
- State codes: IDLE=8'h11, WAIT=8'h21, LOAD=8'h12, SEL=8'h22, RDEN=8'h41, CAPT=8'h42, SEND=8'h44, CSUM=8'h48, DONE=8'h81, ERR=8'h82. Any other code goes to IDLE.
- IDLE -> WAIT unconditionally.
- WAIT -> LOAD when fs=1.
- LOAD latches the length table:
  - dev_type 00: len1=0, len0=0
  - dev_type 01: len1=0x20, len0=0
  - dev_type 10: len1=0x40, len0=0
  - dev_type 11: len1=0x40, len0=0x40
  - LOAD -> SEL.
- SEL:
  - if len1!=0, select channel 1;
  - else if len0!=0, select channel 0;
  - else go to CSUM when the feature is enabled and at least one byte was sent, otherwise to DONE.
  - Otherwise SEL -> RDEN.
- RDEN:
  - When the selected channel's empty=0, drive fifoi_rxen[sel]=1 for exactly one cycle, decrement that channel's counter, clear the timeout counter, and go to CAPT.
  - While empty=1, rxen stays 0 and the timeout counter increments.
  - When the counter reaches TO_CYC-1, go to ERR.
- CAPT: FIFO read latency is 1 cycle. Latch fifoi_rxd byte[sel] into dout, set dout_vld=1, go to SEND.
- SEND: hold dout and dout_vld stable until dout_rdy=1. On the accept cycle, clear dout_vld and go to SEL.
- Throughput is at most one byte per 4 cycles. Only one byte is ever outstanding. No FIFO read is issued while dout_vld=1.
- DONE: fd=1 and rxen=0. Go to WAIT when fs=0.
- ERR:
  - err=1, dout_vld=0, rxen=0, remaining counts discarded.
  - Go to WAIT when fs=0; err clears on that exit.
  - No retry.
- fs dropping mid-frame is ignored; the frame always completes or times out.
- rst mid-frame: immediate return to IDLE, rxen=0 in the same cycle, partial byte discarded.
- dev_type changes after LOAD have no effect until the next frame.
- fifoi_empty asserting between issuing rxen and CAPT is irrelevant; data is taken on the cycle after rxen.

Optional Feature:
- Macro: FIFOI_CHECKSUM_EN.
- Defined: an 8-bit XOR accumulator clears in LOAD and folds in every payload byte accepted in SEND. After the last payload byte, CSUM presents the accumulator on dout with dout_vld=1, using the same handshake, then goes to DONE. No checksum byte is sent when len1+len0=0.
- Undefined: no CSUM state and no accumulator logic. SEL goes straight to DONE.

Decomposition:
- Package fifoi_pkg:
  - state code localparams;
  - LEN_W;
  - function len_lut(dev_type) returning {len1, len0};
  - channel index constants CH0=0, CH1=1.
- No sub-module: the single FSM plus counters fits comfortably in one module.

Test Plan:
- dev_type=01, channel 1 preloaded 0x00..0x1F, fs=1, dout_rdy=1:
  - 32 bytes 0x00..0x1F in order;
  - 32 single-cycle rxen[1] pulses and zero rxen[0] pulses;
  - fd=1; drop fs -> so=8'h21.
- dev_type=11, both channels preloaded with 64 bytes (ch1 0x80.., ch0 0x00..):
  - 64 channel-1 bytes then 64 channel-0 bytes, then fd;
  - fifoi_rxen never equals 2'b11.
- dev_type=00, fs=1: fd=1 within 3 cycles of LOAD; no rxen pulse and no dout_vld.
- Backpressure: hold dout_rdy=0 for 10 cycles mid-frame:
  - dout stable and dout_vld=1 throughout;
  - no rxen during the stall;
  - byte order intact afterwards.
- Timeout: dev_type=11, channel 0 held empty after 64 channel-1 bytes:
  - err=1 exactly TO_CYC cycles after entering RDEN on channel 0;
  - fs low clears err and returns to WAIT.
- With FIFOI_CHECKSUM_EN: dev_type=01 with bytes 0x00..0x1F -> extra byte 0x00 (XOR of 0..31) before fd. With 0x01 and 31×0x00 -> checksum byte 0x01.

Source files
------------

// File: rtl/fifoi_pkg.sv
// Shared definitions for the fifoi read-side scheduler: state codes,
// channel indices, counter width and the device-kind length table.
package fifoi_pkg;

  localparam int LEN_W = 12;

  // Debug-visible state codes (driven on the so port)
  localparam logic [7:0] SC_IDLE = 8'h11;
  localparam logic [7:0] SC_WAIT = 8'h21;
  localparam logic [7:0] SC_LOAD = 8'h12;
  localparam logic [7:0] SC_SEL  = 8'h22;
  localparam logic [7:0] SC_RDEN = 8'h41;
  localparam logic [7:0] SC_CAPT = 8'h42;
  localparam logic [7:0] SC_SEND = 8'h44;
  localparam logic [7:0] SC_CSUM = 8'h48;
  localparam logic [7:0] SC_DONE = 8'h81;
  localparam logic [7:0] SC_ERR  = 8'h82;

  // Channel indices into fifoi_rxen / fifoi_empty / fifoi_rxd byte lanes
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic [7:0] {
    ST_IDLE = SC_IDLE,
    ST_WAIT = SC_WAIT,
    ST_LOAD = SC_LOAD,
    ST_SEL  = SC_SEL,
    ST_RDEN = SC_RDEN,
    ST_CAPT = SC_CAPT,
    ST_SEND = SC_SEND,
    ST_CSUM = SC_CSUM,
    ST_DONE = SC_DONE,
    ST_ERR  = SC_ERR
  } state_e;

  // Per-device byte counts, returned as {len1, len0}
  function automatic logic [2*LEN_W-1:0] len_lut(input logic [1:0] dev_type);
    logic [2*LEN_W-1:0] r;
    case (dev_type)
      2'b00:   r = {LEN_W'(8'h00), LEN_W'(8'h00)};
      2'b01:   r = {LEN_W'(8'h20), LEN_W'(8'h00)};
      2'b10:   r = {LEN_W'(8'h40), LEN_W'(8'h00)};
      2'b11:   r = {LEN_W'(8'h40), LEN_W'(8'h40)};
      default: r = {(2*LEN_W){1'b0}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fifoi_read_sched.sv
// Read-side scheduler for the two per-chip fifoi sample FIFOs.
// Drains channel 1 then channel 0 by the per-device byte count and
// serialises the bytes onto one valid/ready byte stream, then raises fd.
// Optional trailing XOR checksum byte: define FIFOI_CHECKSUM_EN.
// The FIFO read enable is a registered output, so the FIFO data for a
// read shows up one cycle after the enable cycle; CAPT therefore spans
// two cycles (enable cycle, then data cycle).
module fifoi_read_sched
  import fifoi_pkg::*;
#(
  parameter int TO_CYC = 1024,
  parameter int LEN_W  = fifoi_pkg::LEN_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  output logic        err,
  input  logic [1:0]  dev_type,
  output logic [1:0]  fifoi_rxen,
  input  logic [15:0] fifoi_rxd,
  input  logic [1:0]  fifoi_empty,
  output logic [7:0]  dout,
  output logic        dout_vld,
  input  logic        dout_rdy,
  output logic [7:0]  so
);

  localparam int PW   = fifoi_pkg::LEN_W;
  localparam int TO_W = $clog2(TO_CYC) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  state_e            state_q;
  logic              ch_q;
  logic              capt_ph_q;
  logic [LEN_W-1:0]  len1_q;
  logic [LEN_W-1:0]  len0_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              fd_q;
  logic              err_q;
  logic [7:0]        dout_q;
  logic              dout_vld_q;
  logic [1:0]        rxen_q;
`ifdef FIFOI_CHECKSUM_EN
  logic [7:0]        csum_q;
  logic              sent_q;
`endif

  logic [2*PW-1:0]   lut_s;
  logic [7:0]        rxd_byte_s;
  logic              empty_sel_s;

  assign lut_s       = len_lut(dev_type);
  assign rxd_byte_s  = (ch_q == CH1) ? fifoi_rxd[15:8] : fifoi_rxd[7:0];
  assign empty_sel_s = fifoi_empty[ch_q];

  assign fd         = fd_q;
  assign err        = err_q;
  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign fifoi_rxen = rxen_q;
  assign so         = state_q;

  // Scheduler FSM with its counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ch_q       <= CH1;
      capt_ph_q  <= 1'b0;
      len1_q     <= '0;
      len0_q     <= '0;
      to_cnt_q   <= '0;
      fd_q       <= 1'b0;
      err_q      <= 1'b0;
      dout_q     <= 8'h00;
      dout_vld_q <= 1'b0;
      rxen_q     <= 2'b00;
`ifdef FIFOI_CHECKSUM_EN
      csum_q     <= 8'h00;
      sent_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          fd_q       <= 1'b0;
          err_q      <= 1'b0;
          dout_vld_q <= 1'b0;
          rxen_q     <= 2'b00;
          state_q    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (fs) state_q <= ST_LOAD;
        end

        ST_LOAD: begin
          // Lengths are frozen here; later dev_type changes wait for next frame
          len1_q  <= LEN_W'(lut_s[2*PW-1:PW]);
          len0_q  <= LEN_W'(lut_s[PW-1:0]);
`ifdef FIFOI_CHECKSUM_EN
          csum_q  <= 8'h00;
          sent_q  <= 1'b0;
`endif
          state_q <= ST_SEL;
        end

        ST_SEL: begin
          to_cnt_q <= '0;
          if (len1_q != '0) begin
            ch_q    <= CH1;
            state_q <= ST_RDEN;
          end else if (len0_q != '0) begin
            ch_q    <= CH0;
            state_q <= ST_RDEN;
`ifdef FIFOI_CHECKSUM_EN
          end else if (sent_q) begin
            dout_q     <= csum_q;
            dout_vld_q <= 1'b1;
            state_q    <= ST_CSUM;
`endif
          end else begin
            fd_q    <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_RDEN: begin
          if (!empty_sel_s) begin
            rxen_q[ch_q] <= 1'b1;
            if (ch_q == CH1) len1_q <= len1_q - LEN_W'(1);
            else             len0_q <= len0_q - LEN_W'(1);
            to_cnt_q  <= '0;
            capt_ph_q <= 1'b0;
            state_q   <= ST_CAPT;
          end else if (to_cnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            len1_q  <= '0;
            len0_q  <= '0;
            state_q <= ST_ERR;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end

        ST_CAPT: begin
          // First cycle: enable is on the FIFO; second cycle: its data is valid
          rxen_q <= 2'b00;
          if (!capt_ph_q) begin
            capt_ph_q <= 1'b1;
          end else begin
            dout_q     <= rxd_byte_s;
            dout_vld_q <= 1'b1;
            state_q    <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (dout_rdy) begin
            dout_vld_q <= 1'b0;
`ifdef FIFOI_CHECKSUM_EN
            csum_q     <= csum_q ^ dout_q;
            sent_q     <= 1'b1;
`endif
            state_q    <= ST_SEL;
          end
        end

`ifdef FIFOI_CHECKSUM_EN
        ST_CSUM: begin
          if (dout_rdy) begin
            dout_vld_q <= 1'b0;
            fd_q       <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
`endif

        ST_DONE: begin
          rxen_q <= 2'b00;
          if (!fs) begin
            fd_q    <= 1'b0;
            state_q <= ST_WAIT;
          end
        end

        ST_ERR: begin
          dout_vld_q <= 1'b0;
          rxen_q     <= 2'b00;
          if (!fs) begin
            err_q   <= 1'b0;
            state_q <= ST_WAIT;
          end
        end

        default: begin
          fd_q       <= 1'b0;
          err_q      <= 1'b0;
          dout_vld_q <= 1'b0;
          rxen_q     <= 2'b00;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifoi_read_sched.sv
// Directed, table-driven bench for fifoi_read_sched with a two-channel
// FIFO model (1-cycle read latency) and a stream monitor.
module tb_fifoi_read_sched;

  localparam int TO_CYC = 1024;

  logic        clk;
  logic        rst;
  logic        fs;
  logic        fd;
  logic        err;
  logic [1:0]  dev_type;
  logic [1:0]  fifoi_rxen;
  logic [15:0] fifoi_rxd;
  logic [1:0]  fifoi_empty;
  logic [7:0]  dout;
  logic        dout_vld;
  logic        dout_rdy;
  logic [7:0]  so;

  fifoi_read_sched #(.TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .err(err), .dev_type(dev_type),
    .fifoi_rxen(fifoi_rxen), .fifoi_rxd(fifoi_rxd), .fifoi_empty(fifoi_empty),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .so(so)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: contents written by the stimulus, read pointers owned here
  logic [7:0] mem1 [0:127];
  logic [7:0] mem0 [0:127];
  int n1, n0;
  int rp1, rp0;
  logic fifo_clr;

  assign fifoi_empty = {(rp1 >= n1), (rp0 >= n0)};

  always @(posedge clk) begin
    if (fifo_clr) begin
      rp1 <= 0;
      rp0 <= 0;
    end else begin
      if (fifoi_rxen[1] && rp1 < n1) begin
        fifoi_rxd[15:8] <= mem1[rp1];
        rp1 <= rp1 + 1;
      end
      if (fifoi_rxen[0] && rp0 < n0) begin
        fifoi_rxd[7:0] <= mem0[rp0];
        rp0 <= rp0 + 1;
      end
    end
  end

  // Stream monitor: accepted bytes and read-enable statistics
  logic [7:0] rx_q[$];
  int pulses1, pulses0, both_cnt, dbl_cnt, vld_cycles;
  logic [1:0] rxen_prev;
  logic mon_clr;

  always @(posedge clk) begin
    if (mon_clr) begin
      rx_q.delete();
      pulses1 <= 0; pulses0 <= 0; both_cnt <= 0; dbl_cnt <= 0; vld_cycles <= 0;
      rxen_prev <= 2'b00;
    end else begin
      if (dout_vld && dout_rdy) rx_q.push_back(dout);
      if (dout_vld) vld_cycles <= vld_cycles + 1;
      if (fifoi_rxen[1]) pulses1 <= pulses1 + 1;
      if (fifoi_rxen[0]) pulses0 <= pulses0 + 1;
      if (fifoi_rxen == 2'b11) both_cnt <= both_cnt + 1;
      if ((fifoi_rxen & rxen_prev) != 2'b00) dbl_cnt <= dbl_cnt + 1;
      rxen_prev <= fifoi_rxen;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [7:0] b, input int i, input bit incr);
    if (incr) return b + i[7:0];
    return (i == 0) ? b : 8'h00;
  endfunction

  task automatic load_fifo(input logic [7:0] b1, input logic [7:0] b0, input bit incr,
                           input int c1, input int c0);
    fifo_clr = 1'b1;
    mon_clr  = 1'b1;
    for (int i = 0; i < 128; i++) begin
      mem1[i] = pat(b1, i, incr);
      mem0[i] = pat(b0, i, incr);
    end
    n1 = c1;
    n0 = c0;
    @(negedge clk);
    fifo_clr = 1'b0;
    mon_clr  = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int cyc = 0;
    while (!fd && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_fd"}, {31'd0, fd}, 32'd1);
  endtask

  task automatic verify(input string tag, input int e1, input int e0,
                        input logic [7:0] b1, input logic [7:0] b0, input bit incr);
    logic [7:0] exp_q[$];
    logic [7:0] x;
    int bad;
    int lim;
    x = 8'h00;
    bad = 0;
    for (int i = 0; i < e1; i++) exp_q.push_back(pat(b1, i, incr));
    for (int i = 0; i < e0; i++) exp_q.push_back(pat(b0, i, incr));
`ifdef FIFOI_CHECKSUM_EN
    foreach (exp_q[i]) x = x ^ exp_q[i];
    if (exp_q.size() > 0) exp_q.push_back(x);
`endif
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    lim = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) if (rx_q[i] !== exp_q[i]) bad++;
    check({tag, "_bytes_bad"}, bad, 0);
    check({tag, "_rxen1_pulses"}, pulses1, e1);
    check({tag, "_rxen0_pulses"}, pulses0, e0);
    check({tag, "_rxen_both"}, both_cnt, 0);
    check({tag, "_rxen_multicycle"}, dbl_cnt, 0);
  endtask

  task automatic end_frame(input string tag);
    fs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_so_wait"}, so, 8'h21);
    check({tag, "_fd_clr"}, {31'd0, fd}, 32'd0);
  endtask

  task automatic wait_state(input logic [7:0] code, input string tag);
    int cyc = 0;
    while (so !== code && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_reach_state"}, so, code);
  endtask

  typedef struct {
    logic [1:0] dev;
    int         e1;
    int         e0;
    logic [7:0] b1;
    logic [7:0] b0;
    bit         incr;
    string      name;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{2'b00,  0,  0, 8'h00, 8'h00, 1'b1, "dev00"};
    tbl[1] = '{2'b01, 32,  0, 8'h00, 8'h00, 1'b1, "dev01"};
    tbl[2] = '{2'b10, 64,  0, 8'h80, 8'h00, 1'b1, "dev10"};
    tbl[3] = '{2'b11, 64, 64, 8'h80, 8'h00, 1'b1, "dev11"};
    tbl[4] = '{2'b01, 32,  0, 8'h01, 8'h00, 1'b0, "dev01_one"};

    rst = 1'b1; fs = 1'b0; dev_type = 2'b00; dout_rdy = 1'b1;
    fifo_clr = 1'b1; mon_clr = 1'b1; n1 = 0; n0 = 0;
    repeat (3) @(negedge clk);
    check("rst_fd", {31'd0, fd}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_dout", dout, 8'h00);
    check("rst_vld", {31'd0, dout_vld}, 32'd0);
    check("rst_rxen", fifoi_rxen, 2'b00);
    check("rst_so", so, 8'h11);
    rst = 1'b0;
    fifo_clr = 1'b0; mon_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_so", so, 8'h21);

    // Table-driven full frames
    for (int v = 0; v < 5; v++) begin
      load_fifo(tbl[v].b1, tbl[v].b0, tbl[v].incr, 64, 64);
      dev_type = tbl[v].dev;
      dout_rdy = 1'b1;
      fs = 1'b1;
      wait_fd(tbl[v].name);
      verify(tbl[v].name, tbl[v].e1, tbl[v].e0, tbl[v].b1, tbl[v].b0, tbl[v].incr);
      end_frame(tbl[v].name);
    end

    // Zero-length device: done shortly after LOAD, no traffic
    begin
      int cyc;
      load_fifo(8'h00, 8'h00, 1'b1, 64, 64);
      dev_type = 2'b00;
      fs = 1'b1;
      wait_state(8'h12, "zero");
      cyc = 0;
      while (!fd && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      check("zero_fd_within_3", {31'd0, (fd && cyc <= 3)}, 32'd1);
      check("zero_vld_cycles", vld_cycles, 0);
      check("zero_rxen_pulses", pulses1 + pulses0, 0);
      end_frame("zero");
    end

    // Backpressure mid-frame, plus dev_type change after LOAD
    begin
      logic [7:0] held;
      int bad;
      int p;
      int cyc;
      load_fifo(8'h00, 8'h00, 1'b1, 64, 64);
      dev_type = 2'b01;
      fs = 1'b1;
      wait_state(8'h12, "bp");
      @(negedge clk);
      dev_type = 2'b11;
      cyc = 0;
      while (rx_q.size() < 5 && cyc < 4000) begin
        @(negedge clk);
        cyc++;
      end
      dout_rdy = 1'b0;
      cyc = 0;
      while (!dout_vld && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check("bp_vld_seen", {31'd0, dout_vld}, 32'd1);
      held = dout;
      p = pulses1 + pulses0;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (dout !== held || dout_vld !== 1'b1 || fifoi_rxen !== 2'b00) bad++;
      end
      check("bp_stall_bad_cycles", bad, 0);
      check("bp_no_rxen_in_stall", pulses1 + pulses0, p);
      dout_rdy = 1'b1;
      wait_fd("bp");
      verify("bp", 32, 0, 8'h00, 8'h00, 1'b1);
      end_frame("bp");
      dev_type = 2'b00;
    end

    // Timeout on channel 0 after channel 1 drains
    begin
      int cyc;
      load_fifo(8'h80, 8'h00, 1'b1, 64, 0);
      dev_type = 2'b11;
      fs = 1'b1;
      cyc = 0;
      while (!(rx_q.size() == 64 && so == 8'h41) && cyc < 4000) begin
        @(negedge clk);
        cyc++;
      end
      check("to_enter_rden_ch0", so, 8'h41);
      cyc = 0;
      while (!err && cyc < 3 * TO_CYC) begin
        @(negedge clk);
        cyc++;
      end
      check("to_err_latency", cyc, TO_CYC);
      check("to_so_err", so, 8'h82);
      check("to_vld_low", {31'd0, dout_vld}, 32'd0);
      check("to_no_rxen0", pulses0, 0);
      fs = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("to_err_clr", {31'd0, err}, 32'd0);
      check("to_so_wait", so, 8'h21);
    end

    // Asynchronous reset while a read enable is active
    begin
      int cyc;
      load_fifo(8'h80, 8'h00, 1'b1, 64, 64);
      dev_type = 2'b11;
      fs = 1'b1;
      cyc = 0;
      while (fifoi_rxen == 2'b00 && cyc < 4000) begin
        @(negedge clk);
        cyc++;
      end
      check("mrst_rxen_seen", {31'd0, (fifoi_rxen != 2'b00)}, 32'd1);
      rst = 1'b1;
      #1;
      check("mrst_rxen", fifoi_rxen, 2'b00);
      check("mrst_so", so, 8'h11);
      check("mrst_vld", {31'd0, dout_vld}, 32'd0);
      fs = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mrst_so_wait", so, 8'h21);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
